// File: rtl/fetch_pkg.sv
// Shared types, widths and helpers for the LEGv8 instruction-fetch stage.
package fetch_pkg;
  localparam int unsigned ADDR_W  = 64;
  localparam int unsigned INSTR_W = 32;
  localparam int unsigned COUNT_W = 32;

  typedef logic [ADDR_W-1:0]  addr_t;
  typedef logic [INSTR_W-1:0] instr_t;

  localparam instr_t NOP_INSTR_DEFAULT = 32'hD503201F;

  typedef enum logic {RUN, FAULT} fetch_state_t;

  // LOAD captures a fetched word, FLUSH clears the slot on redirect,
  // KILL invalidates the slot but leaves its pc alone.
  typedef enum logic [1:0] {IFID_HOLD, IFID_LOAD, IFID_FLUSH, IFID_KILL} ifid_op_t;

  // True when addr+offset reaches size; widened so wrap near 2^64 cannot hide it.
  function automatic logic past_end(input addr_t addr, input addr_t offset,
                                    input int unsigned size);
    return (65'(addr) + 65'(offset)) >= 65'(size);
  endfunction
endpackage

// File: rtl/fetch_stage_ifid_reg.sv
// IF/ID pipeline register: holds valid, pc and instruction for decode.
module ifid_reg
  import fetch_pkg::*;
#(
  parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  ifid_op_t           op,
  input  logic [ADDR_W-1:0]  load_pc,
  input  logic [INSTR_W-1:0] load_instr,
  output logic               valid,
  output logic [ADDR_W-1:0]  pc,
  output logic [INSTR_W-1:0] instr
);

  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      pc    <= '0;
      instr <= NOP_INSTR;
    end else begin
      case (op)
        IFID_LOAD: begin
          valid <= 1'b1;
          pc    <= load_pc;
          instr <= load_instr;
        end
        IFID_FLUSH: begin
          valid <= 1'b0;
          pc    <= '0;
          instr <= NOP_INSTR;
        end
        IFID_KILL: begin
          valid <= 1'b0;
          instr <= NOP_INSTR;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// LEGv8 instruction-fetch stage: PC, next-PC selection, bounds checks,
// RUN/FAULT control and the IF/ID register feeding decode.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0]  RESET_PC  = 64'd0,
  parameter int unsigned        IMEM_SIZE = 1024,
  parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               ifid_valid,
  output logic [ADDR_W-1:0]  ifid_pc,
  output logic [INSTR_W-1:0] ifid_instr,
  output logic               fault,
  output logic [ADDR_W-1:0]  fault_pc,
  output logic [COUNT_W-1:0] fetch_count
);

  fetch_state_t        state_q, state_d;
  addr_t               pc_q, pc_d;
  addr_t               fault_pc_q, fault_pc_d;
  logic [COUNT_W-1:0]  count_q, count_d;
  ifid_op_t            ifid_op;
  logic                redirect_bad;
  logic                pc_bad;
  logic                seq_past_end;

  assign redirect_bad = (redirect_pc[1:0] != 2'b00)
                      || past_end(redirect_pc, 64'd3, IMEM_SIZE);
  assign pc_bad       = (pc_q[1:0] != 2'b00) || past_end(pc_q, 64'd3, IMEM_SIZE);
  assign seq_past_end = past_end(pc_q, 64'd7, IMEM_SIZE);

  // Next-state: redirect beats a bad current pc, which beats stall and fetch.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    fault_pc_d = fault_pc_q;
    count_d    = count_q;
    ifid_op    = IFID_HOLD;
    case (state_q)
      RUN: begin
        if (redirect_valid) begin
          if (redirect_bad) begin
            state_d    = FAULT;
            fault_pc_d = redirect_pc;
            ifid_op    = IFID_KILL;
          end else begin
            pc_d    = redirect_pc;
            ifid_op = IFID_FLUSH;
          end
        end else if (pc_bad) begin
          state_d    = FAULT;
          fault_pc_d = pc_q;
          ifid_op    = IFID_KILL;
        end else if (!stall) begin
          ifid_op = IFID_LOAD;
          count_d = count_q + COUNT_W'(1);
          if (seq_past_end) begin
            state_d    = FAULT;
            fault_pc_d = pc_q + 64'd4;
          end else begin
            pc_d = pc_q + 64'd4;
          end
        end
      end
      default: ifid_op = IFID_KILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= RUN;
      pc_q       <= RESET_PC;
      fault_pc_q <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      fault_pc_q <= fault_pc_d;
      count_q    <= count_d;
    end
  end

  assign imem_addr   = pc_q;
  assign fault       = (state_q == FAULT);
  assign fault_pc    = fault_pc_q;
  assign fetch_count = count_q;

  ifid_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_ifid (
    .clk        (clk),
    .reset      (reset),
    .op         (ifid_op),
    .load_pc    (pc_q),
    .load_instr (imem_instr),
    .valid      (ifid_valid),
    .pc         (ifid_pc),
    .instr      (ifid_instr)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: directed vector table, end-of-ROM sequence,
// and randomized traffic checked against a behavioural model.
module tb_fetch_stage;
  localparam int unsigned IMEM = 1024;
  localparam logic [31:0] NOP  = 32'hD503201F;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] imem_addr;
  logic [31:0] imem_instr;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        ifid_valid;
  logic [63:0] ifid_pc;
  logic [31:0] ifid_instr;
  logic        fault;
  logic [63:0] fault_pc;
  logic [31:0] fetch_count;

  logic [31:0] rom [256];
  int n_vec = 0;
  int n_err = 0;

  // Reference state, advanced once per clock edge from the fetch rules.
  longint unsigned m_pc, m_ifpc, m_fpc;
  logic            m_valid, m_fault, m_ifpc_known;
  logic [31:0]     m_instr;
  int unsigned     m_cnt;

  always #5 clk = ~clk;

  assign imem_instr = (imem_addr >= 64'(IMEM)) ? 32'h0 : rom[imem_addr[9:2]];

  fetch_stage #(
    .RESET_PC  (64'd0),
    .IMEM_SIZE (IMEM),
    .NOP_INSTR (NOP)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .ifid_valid     (ifid_valid),
    .ifid_pc        (ifid_pc),
    .ifid_instr     (ifid_instr),
    .fault          (fault),
    .fault_pc       (fault_pc),
    .fetch_count    (fetch_count)
  );

  function automatic logic addr_illegal(input longint unsigned a);
    return (a % 4 != 0) || (a > longint'(IMEM - 4));
  endfunction

  task automatic model_step(input logic rst, input logic stl, input logic rv,
                            input longint unsigned rpc);
    if (rst) begin
      m_pc = 0; m_valid = 0; m_ifpc = 0; m_ifpc_known = 1; m_instr = NOP;
      m_fault = 0; m_fpc = 0; m_cnt = 0;
    end else if (m_fault) begin
      m_valid = 0; m_instr = NOP;
    end else if (rv) begin
      m_valid = 0; m_instr = NOP;
      if (addr_illegal(rpc)) begin
        m_fault = 1; m_fpc = rpc; m_ifpc_known = 0;
      end else begin
        m_pc = rpc; m_ifpc = 0; m_ifpc_known = 1;
      end
    end else if (addr_illegal(m_pc)) begin
      m_fault = 1; m_fpc = m_pc; m_valid = 0; m_instr = NOP; m_ifpc_known = 0;
    end else if (!stl) begin
      m_valid = 1; m_ifpc = m_pc; m_ifpc_known = 1; m_instr = rom[m_pc / 4];
      m_cnt = m_cnt + 1;
      if (m_pc + 4 > longint'(IMEM - 4)) begin
        m_fault = 1; m_fpc = m_pc + 4;
      end else begin
        m_pc = m_pc + 4;
      end
    end
  endtask

  // Drive one cycle of inputs, clock it, advance the model, settle.
  task automatic apply(input logic rst, input logic stl, input logic rv,
                       input logic [63:0] rpc);
    reset = rst; stall = stl; redirect_valid = rv; redirect_pc = rpc;
    @(posedge clk);
    model_step(rst, stl, rv, rpc);
    #1;
  endtask

  task automatic check(input string name, input logic e_valid, input logic chk_pc,
                       input logic [63:0] e_ifpc, input logic [31:0] e_instr,
                       input logic [63:0] e_pc, input logic e_fault,
                       input logic [63:0] e_fpc, input logic [31:0] e_cnt);
    n_vec++;
    if (ifid_valid !== e_valid || (chk_pc && ifid_pc !== e_ifpc)
        || ifid_instr !== e_instr || imem_addr !== e_pc || fault !== e_fault
        || fault_pc !== e_fpc || fetch_count !== e_cnt) begin
      n_err++;
      $display("FAIL %s: got valid=%0b ifid_pc=%h instr=%h pc=%h fault=%0b fault_pc=%h count=%0d; want valid=%0b ifid_pc=%h(chk=%0b) instr=%h pc=%h fault=%0b fault_pc=%h count=%0d",
               name, ifid_valid, ifid_pc, ifid_instr, imem_addr, fault, fault_pc,
               fetch_count, e_valid, e_ifpc, chk_pc, e_instr, e_pc, e_fault, e_fpc, e_cnt);
    end
  endtask

  typedef struct {
    logic        rst, stl, rv;
    logic [63:0] rpc;
    logic        valid, chk_pc;
    logic [63:0] ifpc;
    logic [31:0] instr;
    logic [63:0] pc;
    logic        flt;
    logic [63:0] fpc;
    logic [31:0] cnt;
  } vec_t;

  localparam int NTAB = 19;
  vec_t tab [NTAB];

  initial begin
    logic [63:0] rpc;
    logic        r_rst, r_stl, r_rv;

    for (int i = 0; i < 256; i++) rom[i] = $urandom;

    //          rst  stl  rv   rpc                     val chk ifpc    instr    pc      flt fpc                     cnt
    tab[0]  = '{1'b1,1'b0,1'b0,64'h0,                  0,  1,  64'h0,  NOP,     64'h0,  0,  64'h0,                  0};
    tab[1]  = '{1'b0,1'b0,1'b0,64'h0,                  1,  1,  64'h0,  rom[0],  64'h4,  0,  64'h0,                  1};
    tab[2]  = '{1'b0,1'b0,1'b0,64'h0,                  1,  1,  64'h4,  rom[1],  64'h8,  0,  64'h0,                  2};
    tab[3]  = '{1'b0,1'b1,1'b0,64'h0,                  1,  1,  64'h4,  rom[1],  64'h8,  0,  64'h0,                  2};
    tab[4]  = '{1'b0,1'b1,1'b0,64'h0,                  1,  1,  64'h4,  rom[1],  64'h8,  0,  64'h0,                  2};
    tab[5]  = '{1'b0,1'b1,1'b1,64'h40,                 0,  1,  64'h0,  NOP,     64'h40, 0,  64'h0,                  2};
    tab[6]  = '{1'b0,1'b0,1'b0,64'h0,                  1,  1,  64'h40, rom[16], 64'h44, 0,  64'h0,                  3};
    tab[7]  = '{1'b0,1'b0,1'b1,64'h42,                 0,  0,  64'h0,  NOP,     64'h44, 1,  64'h42,                 3};
    tab[8]  = '{1'b0,1'b0,1'b1,64'h10,                 0,  0,  64'h0,  NOP,     64'h44, 1,  64'h42,                 3};
    tab[9]  = '{1'b1,1'b0,1'b0,64'h0,                  0,  1,  64'h0,  NOP,     64'h0,  0,  64'h0,                  0};
    tab[10] = '{1'b0,1'b0,1'b1,64'h1C,                 0,  1,  64'h0,  NOP,     64'h1C, 0,  64'h0,                  0};
    tab[11] = '{1'b0,1'b0,1'b0,64'h0,                  1,  1,  64'h1C, rom[7],  64'h20, 0,  64'h0,                  1};
    tab[12] = '{1'b0,1'b1,1'b0,64'h0,                  1,  1,  64'h1C, rom[7],  64'h20, 0,  64'h0,                  1};
    tab[13] = '{1'b1,1'b1,1'b0,64'h0,                  0,  1,  64'h0,  NOP,     64'h0,  0,  64'h0,                  0};
    tab[14] = '{1'b0,1'b0,1'b1,64'hFFFF_FFFF_FFFF_FFFC,0,  0,  64'h0,  NOP,     64'h0,  1,  64'hFFFF_FFFF_FFFF_FFFC,0};
    tab[15] = '{1'b1,1'b1,1'b0,64'h0,                  0,  1,  64'h0,  NOP,     64'h0,  0,  64'h0,                  0};
    tab[16] = '{1'b0,1'b0,1'b1,64'd1020,               0,  1,  64'h0,  NOP,     64'd1020,0, 64'h0,                  0};
    tab[17] = '{1'b0,1'b0,1'b1,64'd1024,               0,  0,  64'h0,  NOP,     64'd1020,1, 64'd1024,               0};
    tab[18] = '{1'b1,1'b0,1'b0,64'h0,                  0,  1,  64'h0,  NOP,     64'h0,  0,  64'h0,                  0};

    for (int i = 0; i < NTAB; i++) begin
      apply(tab[i].rst, tab[i].stl, tab[i].rv, tab[i].rpc);
      check($sformatf("table[%0d]", i), tab[i].valid, tab[i].chk_pc, tab[i].ifpc,
            tab[i].instr, tab[i].pc, tab[i].flt, tab[i].fpc, tab[i].cnt);
    end

    // Straight-line fetch to the last word, then the sequential fault.
    for (int i = 0; i < 255; i++) apply(1'b0, 1'b0, 1'b0, 64'h0);
    check("seq_pc1020", 1, 1, 64'd1016, rom[254], 64'd1020, 0, 64'h0, 255);
    apply(1'b0, 1'b0, 1'b0, 64'h0);
    check("last_word_valid", 1, 1, 64'd1020, rom[255], 64'd1020, 1, 64'd1024, 256);
    apply(1'b0, 1'b0, 1'b0, 64'h0);
    check("fault_bubble", 0, 0, 64'h0, NOP, 64'd1020, 1, 64'd1024, 256);
    apply(1'b0, 1'b1, 1'b1, 64'h10);
    check("fault_ignores_redirect", 0, 0, 64'h0, NOP, 64'd1020, 1, 64'd1024, 256);
    apply(1'b1, 1'b0, 1'b0, 64'h0);
    check("reset_from_fault", 0, 1, 64'h0, NOP, 64'h0, 0, 64'h0, 0);

    // Random traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      r_rst = ($urandom_range(0, 99) < 3);
      r_stl = ($urandom_range(0, 99) < 25);
      r_rv  = ($urandom_range(0, 99) < 10);
      case ($urandom_range(0, 9))
        0: rpc = 64'({$urandom_range(0, 1023)} | 1);
        1: rpc = 64'(IMEM) + 64'({$urandom_range(0, 63), 2'b00});
        2: rpc = 64'hFFFF_FFFF_FFFF_FF00 | 64'({$urandom_range(0, 63), 2'b00});
        3: rpc = 64'(IMEM - 4) - 64'({$urandom_range(0, 7), 2'b00});
        default: rpc = 64'({$urandom_range(0, 255), 2'b00});
      endcase
      apply(r_rst, r_stl, r_rv, rpc);
      check($sformatf("random[%0d]", i), m_valid, m_ifpc_known, 64'(m_ifpc), m_instr,
            64'(m_pc), m_fault, 64'(m_fpc), m_cnt);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
